pc_unit: RTL and testbench

Parametrised program-counter unit, the successor to the single-register PC. Holds the fetch address and selects the next one from sequential increment, branch, jump, call/return, exception entry and exception return. Includes a small circular return-address stack (RAS) and an exception PC register. Sits at the head of the datapath and drives the instruction-memory address.

---
 rtl/pc_unit.sv | 131 +++++++++++++
 tb/tb_pc_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: selects the next fetch address from sequential, branch,
// jump, call/return and exception sources, with a circular return-address stack.
module pc_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(0),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h80),
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             Branch_Taken,
    input  logic [WIDTH-1:0] Branch_Target,
    input  logic             Jump,
    input  logic             Call,
    input  logic [WIDTH-1:0] Jump_Target,
    input  logic             Ret,
    input  logic [WIDTH-1:0] Ret_Fallback,
    input  logic             Exc,
    input  logic             Eret,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC_Plus4,
    output logic [WIDTH-1:0] EPC,
    output logic             Ras_Empty,
    output logic             Ras_Underflow
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             uf_q, uf_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];

    logic [WIDTH-1:0] pc_plus4;
    logic [PTR_W-1:0] top_idx;
    logic             ras_empty;
    logic             push;

    // Every loaded target is forced word-aligned.
    function automatic logic [WIDTH-1:0] align_w(input logic [WIDTH-1:0] a);
        return a & ~WIDTH'(3);
    endfunction

    assign pc_plus4  = pc_q + WIDTH'(4);
    assign top_idx   = ptr_q - PTR_W'(1);
    assign ras_empty = (cnt_q == CNT_W'(0));

    // Next-PC selection in strict priority order.
    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        uf_d  = 1'b0;
        push  = 1'b0;
        if (Exc) begin
            pc_d  = EXC_VECTOR;
            epc_d = pc_q;
        end else if (Eret) begin
            pc_d = align_w(epc_q);
        end else if (Stall) begin
            pc_d = pc_q;
        end else if (Ret) begin
            if (!ras_empty) begin
                pc_d  = align_w(ras_q[top_idx]);
                ptr_d = top_idx;
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                pc_d = align_w(Ret_Fallback);
                uf_d = 1'b1;
            end
        end else if (Call) begin
            pc_d  = align_w(Jump_Target);
            push  = 1'b1;
            ptr_d = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (Jump) begin
            pc_d = align_w(Jump_Target);
        end else if (Branch_Taken) begin
            pc_d = align_w(Branch_Target);
        end else begin
            pc_d = pc_plus4;
        end
    end

    // Push writes the return address at the pointer; a full stack overwrites the oldest slot.
    always_comb begin
        for (int i = 0; i < int'(RAS_DEPTH); i++) begin
            ras_d[i] = ras_q[i];
        end
        if (push) begin
            ras_d[ptr_q] = pc_plus4;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc_q  <= RESET_VECTOR;
            epc_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
            uf_q  <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            uf_q  <= uf_d;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= ras_d[i];
            end
        end
    end

    assign PC            = pc_q;
    assign PC_Plus4      = pc_plus4;
    assign EPC           = epc_q;
    assign Ras_Empty     = ras_empty;
    assign Ras_Underflow = uf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: a 32-bit instance and an 8-bit instance for wrap.
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        stall, br, jump, call, ret, exc, eret;
    logic [31:0] br_tgt, jt, fb;
    logic [31:0] pc, pc_p4, epc;
    logic        ras_empty, ras_uf;

    logic        br8;
    logic [7:0]  br_tgt8;
    logic [7:0]  pc8, pc_p48, epc8;
    logic        ras_empty8, ras_uf8;

    int n_checks = 0;
    int n_fail   = 0;

    pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h80), .RAS_DEPTH(4)) u_dut (
        .Clk(clk), .Reset(rst_n), .Stall(stall),
        .Branch_Taken(br), .Branch_Target(br_tgt),
        .Jump(jump), .Call(call), .Jump_Target(jt),
        .Ret(ret), .Ret_Fallback(fb), .Exc(exc), .Eret(eret),
        .PC(pc), .PC_Plus4(pc_p4), .EPC(epc),
        .Ras_Empty(ras_empty), .Ras_Underflow(ras_uf)
    );

    pc_unit #(.WIDTH(8), .RESET_VECTOR(8'h0), .EXC_VECTOR(8'h80), .RAS_DEPTH(4)) u_dut8 (
        .Clk(clk), .Reset(rst_n), .Stall(1'b0),
        .Branch_Taken(br8), .Branch_Target(br_tgt8),
        .Jump(1'b0), .Call(1'b0), .Jump_Target(8'h0),
        .Ret(1'b0), .Ret_Fallback(8'h0), .Exc(1'b0), .Eret(1'b0),
        .PC(pc8), .PC_Plus4(pc_p48), .EPC(epc8),
        .Ras_Empty(ras_empty8), .Ras_Underflow(ras_uf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stall = 1'b0; br = 1'b0; jump = 1'b0; call = 1'b0;
        ret = 1'b0; exc = 1'b0; eret = 1'b0;
    endtask

    // One rising edge, then settle to the falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_pc(input string tag, input logic [31:0] exp);
        tick();
        check_eq(tag, pc, exp);
    endtask

    logic [31:0] exp_ret [4];

    initial begin
        rst_n = 1'b0;
        idle();
        br_tgt = '0; jt = '0; fb = '0;
        br8 = 1'b0; br_tgt8 = '0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_epc", epc, 32'h0);
        check_eq("rst_empty", 32'(ras_empty), 32'h1);
        check_eq("rst_uf", 32'(ras_uf), 32'h0);
        rst_n = 1'b1;

        // Sequential fetch after reset.
        step_pc("seq1", 32'h4);
        step_pc("seq2", 32'h8);
        step_pc("seq3", 32'hC);
        check_eq("seq_epc", epc, 32'h0);
        check_eq("seq_empty", 32'(ras_empty), 32'h1);

        // Call then return.
        br = 1'b1; br_tgt = 32'h10;
        step_pc("br_10", 32'h10);
        idle(); call = 1'b1; jt = 32'h100;
        step_pc("call_100", 32'h100);
        check_eq("call_nonempty", 32'(ras_empty), 32'h0);
        idle();
        step_pc("after_call1", 32'h104);
        step_pc("after_call2", 32'h108);
        ret = 1'b1;
        step_pc("ret_14", 32'h14);
        check_eq("ret_empty", 32'(ras_empty), 32'h1);
        check_eq("ret_no_uf", 32'(ras_uf), 32'h0);

        // Five calls to the same target overflow the 4-deep stack.
        idle(); br = 1'b1; br_tgt = 32'h20;
        step_pc("br_20", 32'h20);
        idle(); call = 1'b1; jt = 32'h200;
        for (int i = 0; i < 5; i++) step_pc("call5_same", 32'h200);
        idle(); ret = 1'b1; fb = 32'h300;
        for (int i = 0; i < 4; i++) begin
            step_pc("ret_same", 32'h204);
            check_eq("ret_same_uf", 32'(ras_uf), 32'h0);
        end
        step_pc("ret_fallback", 32'h300);
        check_eq("uf_pulse", 32'(ras_uf), 32'h1);
        idle();
        step_pc("post_uf", 32'h304);
        check_eq("uf_clear", 32'(ras_uf), 32'h0);

        // Distinct call targets expose LIFO order and overwrite of the oldest entry.
        br = 1'b1; br_tgt = 32'h20;
        step_pc("br_20b", 32'h20);
        idle(); call = 1'b1;
        for (int i = 0; i < 5; i++) begin
            jt = 32'h200 + 32'(i) * 32'h10;
            step_pc("call5_dist", 32'h200 + 32'(i) * 32'h10);
        end
        exp_ret[0] = 32'h234; exp_ret[1] = 32'h224;
        exp_ret[2] = 32'h214; exp_ret[3] = 32'h204;
        idle(); ret = 1'b1; fb = 32'h303;
        for (int i = 0; i < 4; i++) step_pc("ret_lifo", exp_ret[i]);
        step_pc("ret_fb_align", 32'h300);
        check_eq("uf_pulse2", 32'(ras_uf), 32'h1);

        // Exception beats Stall and Branch; Eret returns.
        idle(); br = 1'b1; br_tgt = 32'h40;
        step_pc("br_40", 32'h40);
        exc = 1'b1; stall = 1'b1; br_tgt = 32'h998;
        step_pc("exc", 32'h80);
        check_eq("exc_epc", epc, 32'h40);
        idle(); eret = 1'b1;
        step_pc("eret", 32'h40);
        check_eq("eret_epc", epc, 32'h40);

        // Stall holds PC and drops the branch.
        idle(); br = 1'b1; br_tgt = 32'h50;
        step_pc("br_50", 32'h50);
        stall = 1'b1; br_tgt = 32'h500;
        step_pc("stall1", 32'h50);
        step_pc("stall2", 32'h50);
        idle();
        step_pc("stall_rel", 32'h54);

        // Ret and Call together: single pop, no push.
        call = 1'b1; jt = 32'h600;
        step_pc("call_600", 32'h600);
        ret = 1'b1; jt = 32'h700;
        step_pc("ret_call", 32'h58);
        check_eq("ret_call_empty", 32'(ras_empty), 32'h1);

        // Jump does not push; Call beats Jump and does.
        idle(); jump = 1'b1; jt = 32'h702;
        step_pc("jump_align", 32'h700);
        check_eq("jump_nopush", 32'(ras_empty), 32'h1);
        call = 1'b1; jt = 32'h800;
        step_pc("call_jump", 32'h800);
        check_eq("call_jump_push", 32'(ras_empty), 32'h0);
        idle(); ret = 1'b1;
        step_pc("ret_704", 32'h704);
        idle(); br = 1'b1; br_tgt = 32'h123;
        step_pc("br_align", 32'h120);
        check_eq("pc_plus4", pc_p4, 32'h124);

        // Asynchronous reset mid-cycle.
        idle(); exc = 1'b1;
        step_pc("exc2", 32'h80);
        idle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_pc", pc, 32'h0);
        check_eq("arst_epc", epc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step_pc("arst_resume", 32'h4);

        // 8-bit instance: wrap past all-ones.
        br8 = 1'b1; br_tgt8 = 8'hFC;
        tick();
        check_eq("w8_fc", 32'(pc8), 32'hFC);
        check_eq("w8_p4", 32'(pc_p48), 32'h00);
        br8 = 1'b0;
        tick();
        check_eq("w8_wrap", 32'(pc8), 32'h00);
        br8 = 1'b1; br_tgt8 = 8'h33;
        tick();
        check_eq("w8_br", 32'(pc8), 32'h30);
        check_eq("w8_empty", 32'(ras_empty8), 32'h1);
        check_eq("w8_uf", 32'(ras_uf8), 32'h0);
        check_eq("w8_epc", 32'(epc8), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
